// File: rtl/alu_multicycle_if.sv
// alu_multicycle_if: request/response bundle between the ID/EX operand registers and the ALU
interface alu_multicycle_if #(
  parameter int WIDTH = 32
);
  logic             valid_i;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic [3:0]       ctrl_i;
  logic             ready_o;
  logic             done_o;
  logic [WIDTH-1:0] result_o;
  logic [WIDTH-1:0] result_hi_o;
  logic             zero_o;
  logic             ovf_o;
  logic             err_o;
  modport master (
    output valid_i, src1_i, src2_i, ctrl_i,
    input  ready_o, done_o, result_o, result_hi_o, zero_o, ovf_o, err_o
  );
  modport slave (
    input  valid_i, src1_i, src2_i, ctrl_i,
    output ready_o, done_o, result_o, result_hi_o, zero_o, ovf_o, err_o
  );
endinterface

// File: rtl/alu_multicycle.sv
// alu_multicycle: registered handshaked ALU, iterative MULU and optional DIVU (define ALU_DIV_EN)
module alu_multicycle #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input logic             clk_i,
  input logic             rst_i,
  alu_multicycle_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, step, mul_step;
  logic [WIDTH-1:0]   res_q, res_d, hi_q, hi_d;
  logic               zero_q, zero_d, ovf_q, ovf_d, err_q, err_d;
  logic [WIDTH-1:0]   sc_res, sc_hi, sum, diff;
  logic               sc_ovf, sc_err, multi, lt;
  logic [WIDTH:0]     mul_add;
`ifdef ALU_DIV_EN
  logic               div_q, div_d, is_div;
  logic [WIDTH:0]     rem_sh, rem_sub;
`endif
  assign sum  = bus.src1_i + bus.src2_i;
  assign diff = bus.src1_i - bus.src2_i;
  assign lt   = (bus.src1_i[WIDTH-1] != bus.src2_i[WIDTH-1]) ? bus.src1_i[WIDTH-1] : (bus.src1_i < bus.src2_i);
  // Multiply: accumulator is {partial high, remaining multiplier bits}; add then shift right.
  assign mul_add  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  assign mul_step = {mul_add, acc_q[WIDTH-1:1]};
`ifdef ALU_DIV_EN
  // Divide: accumulator is {remainder, dividend bits / quotient bits}; a borrow means restore.
  assign is_div  = bus.ctrl_i == 4'b1001;
  assign rem_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign rem_sub = rem_sh - {1'b0, opnd_q};
  assign step    = div_q ? {rem_sub[WIDTH] ? rem_sh[WIDTH-1:0] : rem_sub[WIDTH-1:0], acc_q[WIDTH-2:0], ~rem_sub[WIDTH]} : mul_step;
`else
  assign step    = mul_step;
`endif
  // Decode the request into a single-cycle result, or flag it as an iterative op.
  always_comb begin
    sc_res = '0;
    sc_hi  = '0;
    sc_ovf = 1'b0;
    sc_err = 1'b0;
    multi  = 1'b0;
    case (bus.ctrl_i)
      4'b0000: sc_res = bus.src1_i & bus.src2_i;
      4'b0001: sc_res = bus.src1_i | bus.src2_i;
      4'b0010: begin
        sc_res = sum;
        sc_ovf = (bus.src1_i[WIDTH-1] == bus.src2_i[WIDTH-1]) && (sum[WIDTH-1] != bus.src1_i[WIDTH-1]);
      end
      4'b0110: begin
        sc_res = diff;
        sc_ovf = (bus.src1_i[WIDTH-1] != bus.src2_i[WIDTH-1]) && (diff[WIDTH-1] != bus.src1_i[WIDTH-1]);
      end
      4'b0111: sc_res = WIDTH'(lt);
      4'b1100: sc_res = ~(bus.src1_i | bus.src2_i);
      4'b1000: multi = 1'b1;
`ifdef ALU_DIV_EN
      4'b1001: begin
        multi  = bus.src2_i != '0;
        sc_res = '1;
        sc_hi  = bus.src1_i;
      end
`endif
      default: sc_err = 1'b1;
    endcase
  end
  // Control and datapath next state: iterate in BUSY, accept whenever not BUSY.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    res_d   = res_q;
    hi_d    = hi_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
`ifdef ALU_DIV_EN
    div_d   = div_q;
`endif
    if (state_q == BUSY) begin
      acc_d = step;
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == LAST) begin
        state_d = DONE;
        cnt_d   = '0;
        res_d   = step[WIDTH-1:0];
        hi_d    = step[2*WIDTH-1:WIDTH];
        zero_d  = ~|step[WIDTH-1:0];
        ovf_d   = 1'b0;
        err_d   = 1'b0;
      end
    end else if (bus.valid_i && multi) begin
      state_d = BUSY;
      cnt_d   = '0;
`ifdef ALU_DIV_EN
      div_d   = is_div;
      opnd_d  = is_div ? bus.src2_i : bus.src1_i;
      acc_d   = {{WIDTH{1'b0}}, is_div ? bus.src1_i : bus.src2_i};
`else
      opnd_d  = bus.src1_i;
      acc_d   = {{WIDTH{1'b0}}, bus.src2_i};
`endif
    end else if (bus.valid_i) begin
      state_d = DONE;
      res_d   = sc_res;
      hi_d    = sc_hi;
      zero_d  = ~|sc_res;
      ovf_d   = sc_ovf;
      err_d   = sc_err;
    end else begin
      state_d = IDLE;
    end
  end
  // State and result registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      hi_q    <= '0;
      zero_q  <= 1'b1;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef ALU_DIV_EN
      div_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
`ifdef ALU_DIV_EN
      div_q   <= div_d;
`endif
    end
  end
  assign bus.ready_o     = state_q != BUSY;
  assign bus.done_o      = state_q == DONE;
  assign bus.result_o    = res_q;
  assign bus.result_hi_o = hi_q;
  assign bus.zero_o      = zero_q;
  assign bus.ovf_o       = ovf_q;
  assign bus.err_o       = err_q;
endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: directed vector table, corner sequences and randomized ops against an arithmetic model
module tb_alu_multicycle;
  localparam int W = 32;
  localparam int ML = W + 1;
  typedef struct {
    logic [3:0]   c;
    logic [W-1:0] a, b, r, h;
    logic         z, o, e;
    int           lat;
  } vec_t;
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int checks = 0;
  int failures = 0;
  vec_t tbl[$];
  alu_multicycle_if #(.WIDTH(W)) bus ();
  alu_multicycle #(.WIDTH(W)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));
  always #5 clk_i = ~clk_i;
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got=timeout required=finish");
    $fatal(1);
  end
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h required=%h", name, got, exp);
    end
  endtask
  task automatic add(input logic [3:0] c, input logic [W-1:0] a, b, r, h, input logic z, o, e, input int lat);
    vec_t v;
    v.c = c; v.a = a; v.b = b; v.r = r; v.h = h; v.z = z; v.o = o; v.e = e; v.lat = lat;
    tbl.push_back(v);
  endtask
  function automatic void model(input logic [3:0] c, input logic [W-1:0] a, b,
                                output logic [W-1:0] r, h, output logic o, e, output int lat);
    longint sa, sb, t;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0; h = '0; o = 1'b0; e = 1'b0; lat = 1;
    case (c)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: begin t = sa + sb; r = t[W-1:0]; o = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
      4'b0110: begin t = sa - sb; r = t[W-1:0]; o = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
      4'b0111: r = (sa < sb) ? 1 : 0;
      4'b1100: r = ~(a | b);
      4'b1000: begin p = {32'b0, a} * {32'b0, b}; r = p[W-1:0]; h = p[63:W]; lat = ML; end
`ifdef ALU_DIV_EN
      4'b1001: if (b == 0) begin r = '1; h = a; end else begin r = a / b; h = a % b; lat = ML; end
`endif
      default: e = 1'b1;
    endcase
  endfunction
  // Starts at #1 after an edge with the block ready; returns at #1 after the edge where done_o is seen.
  task automatic run_op(input logic [3:0] c, input logic [W-1:0] a, b,
                        output logic [W-1:0] r, h, output logic z, o, e, output int lat, output int busy_bad);
    bus.valid_i = 1'b1; bus.ctrl_i = c; bus.src1_i = a; bus.src2_i = b;
    @(posedge clk_i); #1;
    bus.valid_i = 1'b0; bus.ctrl_i = 4'($urandom); bus.src1_i = $urandom; bus.src2_i = $urandom;
    lat = 1; busy_bad = 0;
    while (!bus.done_o && lat < 100) begin
      if (bus.ready_o) busy_bad++;
      @(posedge clk_i); #1;
      lat++;
    end
    r = bus.result_o; h = bus.result_hi_o; z = bus.zero_o; o = bus.ovf_o; e = bus.err_o;
  endtask
  initial begin
    logic [W-1:0] r, h, er, eh;
    logic z, o, e, eo, ee;
    int lat, elat, bb, cnt;
    logic [3:0] ops [8];
    logic [3:0] c;
    logic [W-1:0] a, b;
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1000, 4'b1001};
    add(4'b0010, 32'h7FFFFFFF, 32'h1, 32'h80000000, 0, 0, 1, 0, 1);
    add(4'b0110, 32'd5, 32'd5, 32'h0, 0, 1, 0, 0, 1);
    add(4'b0111, 32'hFFFFFFFF, 32'h1, 32'h1, 0, 0, 0, 0, 1);
    add(4'b0111, 32'd3, 32'd2, 32'h0, 0, 1, 0, 0, 1);
    add(4'b1100, 32'h0, 32'h0, 32'hFFFFFFFF, 0, 0, 0, 0, 1);
    add(4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFE, 0, 0, 0, ML);
    add(4'b0101, 32'h1234, 32'h5678, 32'h0, 0, 1, 0, 1, 1);
    add(4'b0110, 32'h80000000, 32'h1, 32'h7FFFFFFF, 0, 0, 1, 0, 1);
    add(4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 0, 0, 0, 1);
    add(4'b0001, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 0, 0, 0, 0, 1);
    add(4'b1000, 32'h10000, 32'h10000, 32'h0, 32'h1, 1, 0, 0, ML);
    add(4'b0111, 32'h7FFFFFFF, 32'h80000000, 32'h0, 0, 1, 0, 0, 1);
`ifdef ALU_DIV_EN
    add(4'b1001, 32'd100, 32'd7, 32'd14, 32'd2, 0, 0, 0, ML);
    add(4'b1001, 32'd9, 32'd0, 32'hFFFFFFFF, 32'd9, 0, 0, 0, 1);
`else
    add(4'b1001, 32'd100, 32'd7, 32'h0, 32'h0, 1, 0, 1, 1);
    add(4'b1001, 32'd9, 32'd0, 32'h0, 32'h0, 1, 0, 1, 1);
`endif
    bus.valid_i = 1'b0; bus.ctrl_i = '0; bus.src1_i = '0; bus.src2_i = '0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b1;
    chk("rst_ready", bus.ready_o, 1);
    chk("rst_done", bus.done_o, 0);
    chk("rst_result", bus.result_o, 0);
    chk("rst_hi", bus.result_hi_o, 0);
    chk("rst_zero", bus.zero_o, 1);
    chk("rst_ovf", bus.ovf_o, 0);
    chk("rst_err", bus.err_o, 0);
    @(posedge clk_i); #1;
    chk("idle_done", bus.done_o, 0);
    foreach (tbl[i]) begin
      run_op(tbl[i].c, tbl[i].a, tbl[i].b, r, h, z, o, e, lat, bb);
      chk($sformatf("vec%0d_result", i), r, tbl[i].r);
      chk($sformatf("vec%0d_hi", i), h, tbl[i].h);
      chk($sformatf("vec%0d_zero", i), z, tbl[i].z);
      chk($sformatf("vec%0d_ovf", i), o, tbl[i].o);
      chk($sformatf("vec%0d_err", i), e, tbl[i].e);
      chk($sformatf("vec%0d_latency", i), lat, tbl[i].lat);
      chk($sformatf("vec%0d_ready_low_busy", i), bb, 0);
    end
    @(posedge clk_i); #1;
    chk("done_single_pulse", bus.done_o, 0);
    bus.valid_i = 1'b1; bus.ctrl_i = 4'b1000; bus.src1_i = 32'hFFFFFFFF; bus.src2_i = 32'hFFFFFFFF;
    @(posedge clk_i); #1;
    lat = 1; bb = 0;
    while (!bus.done_o && lat < 100) begin
      bus.valid_i = (lat == 5); bus.ctrl_i = 4'b0010; bus.src1_i = 32'd1; bus.src2_i = 32'd1;
      if (bus.ready_o) bb++;
      @(posedge clk_i); #1;
      lat++;
    end
    bus.valid_i = 1'b0;
    chk("mul_ignore_latency", lat, ML);
    chk("mul_ignore_ready", bb, 0);
    chk("mul_ignore_lo", bus.result_o, 32'h1);
    chk("mul_ignore_hi", bus.result_hi_o, 32'hFFFFFFFE);
    @(posedge clk_i); #1;
    chk("mul_ignore_no_queue", bus.done_o, 0);
    bus.valid_i = 1'b1; bus.ctrl_i = 4'b0010; bus.src1_i = 32'd1; bus.src2_i = 32'd2;
    @(posedge clk_i); #1;
    chk("b2b_add_done", bus.done_o, 1);
    chk("b2b_add_res", bus.result_o, 32'd3);
    bus.ctrl_i = 4'b0001; bus.src1_i = 32'd5; bus.src2_i = 32'd10;
    @(posedge clk_i); #1;
    chk("b2b_or_done", bus.done_o, 1);
    chk("b2b_or_res", bus.result_o, 32'd15);
    bus.ctrl_i = 4'b0000; bus.src1_i = 32'hC; bus.src2_i = 32'hA;
    @(posedge clk_i); #1;
    bus.valid_i = 1'b0;
    chk("b2b_and_done", bus.done_o, 1);
    chk("b2b_and_res", bus.result_o, 32'h8);
    @(posedge clk_i); #1;
    chk("b2b_end_done", bus.done_o, 0);
    bus.valid_i = 1'b1; bus.ctrl_i = 4'b1000; bus.src1_i = 32'd3; bus.src2_i = 32'd5;
    @(posedge clk_i); #1;
    bus.valid_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    chk("abort_ready", bus.ready_o, 1);
    chk("abort_done", bus.done_o, 0);
    chk("abort_result", bus.result_o, 0);
    chk("abort_zero", bus.zero_o, 1);
    cnt = 0;
    repeat (ML + 8) begin
      @(posedge clk_i); #1;
      if (bus.done_o) cnt++;
    end
    chk("abort_no_done", cnt, 0);
    for (int i = 0; i < 200; i++) begin
      int k;
      k = $urandom_range(0, 8);
      c = (k == 8) ? 4'($urandom) : ops[k];
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'($urandom_range(0, 15));
        1: b = 32'h80000000 ^ 32'($urandom_range(0, 3));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = b;
      model(c, a, b, er, eh, eo, ee, elat);
      run_op(c, a, b, r, h, z, o, e, lat, bb);
      chk($sformatf("rnd%0d_c%h_result", i, c), r, er);
      chk($sformatf("rnd%0d_c%h_hi", i, c), h, eh);
      chk($sformatf("rnd%0d_c%h_zero", i, c), z, er == 0);
      chk($sformatf("rnd%0d_c%h_ovf", i, c), o, eo);
      chk($sformatf("rnd%0d_c%h_err", i, c), e, ee);
      chk($sformatf("rnd%0d_c%h_latency", i, c), lat, elat);
      chk($sformatf("rnd%0d_c%h_ready_low_busy", i, c), bb, 0);
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk_i); #1;
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
